// File: rtl/io_port_responder.sv
// io_port_responder: CPU port-bus peripheral with output registers, synchronized inputs,
// an interval timer and debounced buttons driving a pulsed interrupt.
module io_port_responder #(
    parameter logic [7:0] LEDS_ID     = 8'h40,
    parameter logic [7:0] SSEG_ID     = 8'h81,
    parameter logic [7:0] SW_ID       = 8'h20,
    parameter logic [7:0] BTN_ID      = 8'h24,
    parameter logic [7:0] TMR_LO_ID   = 8'hB0,
    parameter logic [7:0] TMR_HI_ID   = 8'hB1,
    parameter logic [7:0] TMR_CTRL_ID = 8'hB2,
    parameter logic [7:0] STATUS_ID   = 8'hB3,
    parameter int         DEB_CYCLES  = 10000,
    parameter int         INT_PULSE   = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] PORT_ID,
    input  logic [7:0] OUT_PORT,
    input  logic       IO_STRB,
    output logic [7:0] IN_PORT,
    output logic       INTERRUPTC,
    input  logic [7:0] SWITCHES,
    input  logic [3:0] BTN,
    output logic [7:0] LEDS,
    output logic [7:0] SSEG_DATA
);
    localparam int DW = $clog2(DEB_CYCLES);
    localparam int PW = $clog2(INT_PULSE + 1);

    logic [7:0]    sw_s1, sw_s2, period_lo, period_hi;
    logic [3:0]    btn_s1, btn_s2, btn_deb, btn_rise;
    logic [DW-1:0] deb_cnt [4];
    logic [2:0]    ctrl;
    logic [1:0]    flg, clr;
    logic [15:0]   count, period;
    logic [PW-1:0] pulse;
    logic          tmr_wr, run, fire, irq_q, irq_d;

    assign period = {period_hi, period_lo};
    assign tmr_wr = IO_STRB && (PORT_ID == TMR_LO_ID || PORT_ID == TMR_HI_ID || PORT_ID == TMR_CTRL_ID);
    assign run    = ctrl[0] && period != 16'd0;
    assign fire   = !tmr_wr && run && count == period;
    assign clr    = (IO_STRB && PORT_ID == STATUS_ID) ? OUT_PORT[1:0] : 2'b00;
    assign INTERRUPTC = pulse != '0;

    // A button is accepted on the edge its counter of differing samples saturates.
    always_comb
        for (int i = 0; i < 4; i++)
            btn_rise[i] = btn_s2[i] && !btn_deb[i] && deb_cnt[i] == DW'(DEB_CYCLES - 1);

    always_comb
        IN_PORT = PORT_ID == SW_ID       ? sw_s2 :
                  PORT_ID == BTN_ID      ? {4'b0, btn_deb} :
                  PORT_ID == TMR_LO_ID   ? period_lo :
                  PORT_ID == TMR_HI_ID   ? period_hi :
                  PORT_ID == TMR_CTRL_ID ? {5'b0, ctrl} :
                  PORT_ID == STATUS_ID   ? {6'b0, flg} : 8'h00;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            LEDS      <= '0;
            SSEG_DATA <= '0;
            period_lo <= '0;
            period_hi <= '0;
            ctrl      <= '0;
        end else if (IO_STRB) begin
            if (PORT_ID == LEDS_ID)     LEDS      <= OUT_PORT;
            if (PORT_ID == SSEG_ID)     SSEG_DATA <= OUT_PORT;
            if (PORT_ID == TMR_LO_ID)   period_lo <= OUT_PORT;
            if (PORT_ID == TMR_HI_ID)   period_hi <= OUT_PORT;
            if (PORT_ID == TMR_CTRL_ID) ctrl      <= OUT_PORT[2:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            btn_s1 <= '0;
            btn_s2 <= '0;
        end else begin
            sw_s1  <= SWITCHES;
            sw_s2  <= sw_s1;
            btn_s1 <= BTN;
            btn_s2 <= btn_s1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            deb_cnt <= '{default: '0};
            btn_deb <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (btn_s2[i] == btn_deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
                    deb_cnt[i] <= '0;
                    btn_deb[i] <= btn_s2[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            count <= '0;
            flg   <= '0;
            irq_q <= 1'b0;
            irq_d <= 1'b0;
            pulse <= '0;
        end else begin
            count <= (tmr_wr || fire) ? 16'd0 : run ? count + 16'd1 : count;
            flg   <= (flg & ~clr) | {|btn_rise, fire};
            irq_q <= |(flg & ctrl[2:1]);
            irq_d <= irq_q;
            pulse <= (irq_q && !irq_d) ? PW'(INT_PULSE) : pulse != '0 ? pulse - 1'b1 : pulse;
        end
    end
endmodule

// File: tb/tb_io_port_responder.sv
// tb_io_port_responder: directed scenarios plus random traffic, checked every cycle
// against a history-based behavioural model of the port responder.
module tb_io_port_responder;
    localparam int DEB = 4;
    localparam int IP  = 4;

    logic       CLK = 1'b0, RESET = 1'b1, IO_STRB = 1'b0, INTERRUPTC;
    logic [7:0] PORT_ID = '0, OUT_PORT = '0, SWITCHES = '0, IN_PORT, LEDS, SSEG_DATA;
    logic [3:0] BTN = '0;
    int         n_vec = 0, n_err = 0, n_hi = 0, k = 0;

    always #5 CLK = ~CLK;

    io_port_responder #(.DEB_CYCLES(DEB), .INT_PULSE(IP)) dut (
        .CLK(CLK), .RESET(RESET), .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT), .IO_STRB(IO_STRB),
        .IN_PORT(IN_PORT), .INTERRUPTC(INTERRUPTC), .SWITCHES(SWITCHES), .BTN(BTN),
        .LEDS(LEDS), .SSEG_DATA(SSEG_DATA)
    );

    // Model: input histories (index 0 = sampled at latest edge), registers, and a history of
    // the pending-interrupt condition from which pulses are derived.
    logic [7:0] m_leds = '0, m_sseg = '0, m_lo = '0, m_hi = '0;
    logic [2:0] m_ctl = '0;
    logic [1:0] m_flg = '0;
    logic [3:0] m_deb = '0, m_dn;
    logic [7:0] m_sw [2]      = '{default: '0};
    logic [3:0] m_bh [DEB+1]  = '{default: '0};
    logic       m_rh [IP+3]   = '{default: 1'b0};
    logic       m_intc = 1'b0, m_fire, m_tw, m_stable;
    int         m_cnt = 0, m_per;
    logic [7:0] ids [8] = '{8'h40, 8'h81, 8'h20, 8'h24, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
    logic [7:0] r_p, r_d;

    always @(posedge CLK) begin
        if (RESET) begin
            m_leds = '0; m_sseg = '0; m_lo = '0; m_hi = '0; m_ctl = '0; m_flg = '0; m_deb = '0; m_cnt = 0;
            m_sw = '{default: '0}; m_bh = '{default: '0}; m_rh = '{default: 1'b0};
        end else begin
            m_dn = m_deb;
            for (int i = 0; i < 4; i++) begin
                m_stable = 1'b1;
                for (int j = 1; j <= DEB; j++) if (m_bh[j][i] == m_deb[i]) m_stable = 1'b0;
                if (m_stable) m_dn[i] = ~m_deb[i];
            end
            m_per  = {m_hi, m_lo};
            m_tw   = IO_STRB && PORT_ID inside {8'hB0, 8'hB1, 8'hB2};
            m_fire = !m_tw && m_ctl[0] && m_per != 0 && m_cnt == m_per;
            if (m_tw || m_fire) m_cnt = 0;
            else if (m_ctl[0] && m_per != 0) m_cnt++;
            if (IO_STRB && PORT_ID == 8'hB3) m_flg = m_flg & ~OUT_PORT[1:0];
            m_flg = m_flg | {|(m_dn & ~m_deb), m_fire};
            m_deb = m_dn;
            if (IO_STRB)
                case (PORT_ID)
                    8'h40: m_leds = OUT_PORT;
                    8'h81: m_sseg = OUT_PORT;
                    8'hB0: m_lo = OUT_PORT;
                    8'hB1: m_hi = OUT_PORT;
                    8'hB2: m_ctl = OUT_PORT[2:0];
                    default: ;
                endcase
            for (int j = DEB; j > 0; j--) m_bh[j] = m_bh[j-1];
            m_bh[0] = BTN;
            m_sw[1] = m_sw[0];
            m_sw[0] = SWITCHES;
            for (int j = IP + 2; j > 0; j--) m_rh[j] = m_rh[j-1];
            m_rh[0] = |(m_flg & m_ctl[2:1]);
        end
        m_intc = 1'b0;
        for (int j = 0; j < IP; j++) if (m_rh[j+2] && !m_rh[j+3]) m_intc = 1'b1;
    end

    function automatic logic [7:0] exp_in(logic [7:0] p);
        case (p)
            8'h20:   return m_sw[1];
            8'h24:   return {4'h0, m_deb};
            8'hB0:   return m_lo;
            8'hB1:   return m_hi;
            8'hB2:   return {5'b0, m_ctl};
            8'hB3:   return {6'b0, m_flg};
            default: return 8'h00;
        endcase
    endfunction

    task automatic check(string tag, logic [15:0] got, logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
        check("in_port", 16'(IN_PORT), 16'(exp_in(PORT_ID)));
        check("interruptc", 16'(INTERRUPTC), 16'(m_intc));
        check("leds", 16'(LEDS), 16'(m_leds));
        check("sseg", 16'(SSEG_DATA), 16'(m_sseg));
        if (INTERRUPTC) n_hi++;
    endtask

    task automatic io(logic [7:0] p, logic [7:0] d, logic s);
        PORT_ID = p; OUT_PORT = d; IO_STRB = s;
        cyc();
        IO_STRB = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        io(8'h00, 8'h00, 1'b0);
        io(8'h00, 8'h00, 1'b0);
        RESET = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst_leds", 16'(LEDS), 16'h0);
        check("rst_intc", 16'(INTERRUPTC), 16'h0);
        io(8'h40, 8'hA5, 1'b1);  check("t1_leds_wr", 16'(LEDS), 16'hA5);
        io(8'h40, 8'h11, 1'b0);  check("t1_no_strb", 16'(LEDS), 16'hA5);
        io(8'h55, 8'h00, 1'b0);  check("t1_unmapped", 16'(IN_PORT), 16'h00);
        SWITCHES = 8'h3C;
        io(8'h20, 8'h00, 1'b0);  check("t2_sw_early", 16'(IN_PORT), 16'h00);
        io(8'h20, 8'h00, 1'b0);  check("t2_sw_sync", 16'(IN_PORT), 16'h3C);

        do_reset();
        io(8'hB0, 8'h09, 1'b1); io(8'hB1, 8'h00, 1'b1); io(8'hB2, 8'h03, 1'b1);
        n_hi = 0;
        for (int i = 0; i < 30; i++) io(8'hB3, 8'h00, 1'b0);
        check("t3_one_pulse", 16'(n_hi), 16'd4);
        io(8'hB3, 8'h01, 1'b1);  check("t3_w1c", 16'(IN_PORT), 16'h00);
        n_hi = 0;
        for (int i = 0; i < 16; i++) io(8'hB3, 8'h00, 1'b0);
        check("t3_rearm", 16'(n_hi), 16'd4);

        do_reset();
        n_hi = 0;
        BTN = 4'h4;
        io(8'h00, 8'h00, 1'b0); io(8'h00, 8'h00, 1'b0);
        BTN = 4'h0;
        for (int i = 0; i < 6; i++) io(8'h00, 8'h00, 1'b0);
        io(8'hB3, 8'h00, 1'b0);  check("t4_glitch", 16'(IN_PORT), 16'h00);
        BTN = 4'h4;
        for (int i = 0; i < 10; i++) io(8'h24, 8'h00, 1'b0);
        check("t4_btn", 16'(IN_PORT), 16'h04);
        io(8'hB3, 8'h00, 1'b0);  check("t4_status", 16'(IN_PORT), 16'h02);
        check("t4_no_irq", 16'(n_hi), 16'd0);
        BTN = 4'h0;

        do_reset();
        io(8'hB0, 8'h09, 1'b1); io(8'hB1, 8'h00, 1'b1); io(8'hB2, 8'h03, 1'b1);
        n_hi = 0;
        for (int i = 0; i < 19; i++) io(8'hB3, 8'h00, 1'b0);
        io(8'hB3, 8'h01, 1'b1);  check("t5_set_wins", 16'(IN_PORT), 16'h01);
        for (int i = 0; i < 10; i++) io(8'hB3, 8'h00, 1'b0);
        check("t5_no_repulse", 16'(n_hi), 16'd4);
        io(8'hB0, 8'h00, 1'b1); io(8'hB1, 8'h00, 1'b1); io(8'hB3, 8'h03, 1'b1);
        n_hi = 0;
        for (int i = 0; i < 100; i++) io(8'hB3, 8'h00, 1'b0);
        check("t5_period0", 16'(IN_PORT), 16'h00);
        check("t5_period0_irq", 16'(n_hi), 16'd0);

        do_reset();
        io(8'h40, 8'hFF, 1'b1); io(8'hB0, 8'h02, 1'b1); io(8'hB2, 8'h03, 1'b1);
        k = 0;
        while (!INTERRUPTC && k < 50) begin
            io(8'h00, 8'h00, 1'b0);
            k++;
        end
        check("t6_pulse_seen", 16'(INTERRUPTC), 16'h1);
        io(8'h00, 8'h00, 1'b0);  check("t6_second", 16'(INTERRUPTC), 16'h1);
        RESET = 1'b1;
        io(8'hB0, 8'h00, 1'b0);
        RESET = 1'b0;
        check("t6_intc", 16'(INTERRUPTC), 16'h0);
        check("t6_leds", 16'(LEDS), 16'h00);
        check("t6_period", 16'(IN_PORT), 16'h00);

        for (int c = 0; c < 2500; c++) begin
            r_p = ids[$urandom_range(0, 7)];
            if ($urandom_range(0, 8) == 0) r_p = 8'($urandom);
            r_d = r_p == 8'hB1 ? ($urandom_range(0, 3) == 0 ? 8'h01 : 8'h00) :
                  r_p == 8'hB0 ? 8'($urandom_range(0, 20)) : 8'($urandom);
            if ($urandom_range(0, 15) == 0) BTN = 4'($urandom);
            if ($urandom_range(0, 7) == 0) SWITCHES = 8'($urandom);
            RESET = $urandom_range(0, 499) == 0;
            io(r_p, r_d, $urandom_range(0, 3) == 0);
        end
        RESET = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
